demod_frame_sequencer: RTL and testbench
========================================

// Module: demod_frame_sequencer
// PURPOSE
//  AXI4-Lite-configured sequencer that gates the demodulator's output symbol stream into framed AXI-Stream packets.
//  Software programs the frame length and frame count, then issues START.
//  The block then passes exactly FRAME_LEN*NUM_FRAMES beats, asserting TLAST on the last beat of each frame, and reports progress.
//  It sits between the demodulator core's AXI-Stream output and the downstream DMA/stream sink, on the same S00_AXI control bus.
// PARAMETERS
//  C_S_AXI_DATA_WIDTH  32  AXI4-Lite data width (only 32 supported)
//  C_S_AXI_ADDR_WIDTH  4   AXI4-Lite address width; register select = awaddr/araddr[3:2]
//  C_AXIS_TDATA_WIDTH  32  symbol stream width (pass-through, unmodified)
// PORTS
//  ACLK           in   1    single clock for all logic
//  ARESETN        in   1    asynchronous active-low reset
//  s_axi_awaddr   in   4    write address
//  s_axi_awvalid  in   1    / s_axi_awready out 1: write address handshake
//  s_axi_wdata    in   32   write data (wstrb ignored; full-word writes only)
//  s_axi_wvalid   in   1    / s_axi_wready  out 1: write data handshake
//  s_axi_bresp    out  2    always 2'b00 (OKAY)
//  s_axi_bvalid   out  1    / s_axi_bready  in  1: write response handshake
//  s_axi_araddr   in   4    read address
//  s_axi_arvalid  in   1    / s_axi_arready out 1: read address handshake
//  s_axi_rdata    out  32   read data
//  s_axi_rresp    out  2    always 2'b00
//  s_axi_rvalid   out  1    / s_axi_rready  in  1: read data handshake
//  s_axis_tdata   in   32   demodulated symbols, with s_axis_tvalid in 1 / s_axis_tready out 1
//  m_axis_tdata   out  32   framed output, with m_axis_tvalid out 1 / m_axis_tready in 1
//  m_axis_tlast   out  1    last beat of each frame
// BEHAVIOUR
//  Reset values (async, ARESETN=0): state IDLE; all *ready/*valid outputs 0; all registers, counters and status 0.
//  AXI-Lite write
//   - awready and wready pulse together for 1 cycle when awvalid & wvalid & !bvalid.
//   - bvalid rises the next cycle and holds until bready.
//   - A lone AW or W waits; it is never accepted alone.
//  AXI-Lite read
//   - arready pulses for 1 cycle when arvalid & !rvalid.
//   - rdata/rvalid appear the next cycle and hold until rready.
//   - Reads and writes are fully independent.
//  Register map
//   - 0x0 CTRL: [0] EN; [1] START (self-clearing, reads 0); [2] ABORT (self-clearing, reads 0).
//   - 0x4 FRAME_LEN [15:0], R/W.
//   - 0x8 NUM_FRAMES [15:0], R/W.
//   - 0xC STATUS
//     - [0] BUSY (RO).
//     - [1] DONE: sticky; cleared by START.
//     - [2] ERR: sticky; W1C.
//     - [31:16] FRAMES_DONE (RO).
//  Shadowing: FRAME_LEN and NUM_FRAMES are copied into shadow registers at START; writes during RUN affect only the next run.
//  FSM
//   - IDLE -> RUN on START when EN=1, FRAME_LEN!=0 and NUM_FRAMES!=0.
//     - START clears DONE and FRAMES_DONE and zeroes beat_cnt.
//     - START with EN=0 or with a zero length/count: stays IDLE and sets ERR.
//   - RUN -> IDLE on the handshake of the last beat of frame NUM_FRAMES; sets DONE the same edge.
//   - RUN -> IDLE on ABORT or on EN written 0: partial frame is truncated with no TLAST; sets ERR; DONE stays 0.
//   - START written while in RUN is ignored (no ERR).
//  Datapath
//   - RUN, combinational pass-through, 0-cycle latency:
//     - m_tvalid = s_tvalid; s_tready = m_tready; m_tdata = s_tdata.
//     - m_tlast = (beat_cnt == FRAME_LEN_sh-1).
//   - IDLE: m_tvalid=0, m_tlast=0; s_tready = EN.
//     - EN=1 flushes/discards demod output; EN=0 backpressures it.
//  Counters
//   - beat_cnt (16b) increments on the m_axis handshake and wraps to 0 after the TLAST beat.
//   - FRAMES_DONE (16b) increments on each TLAST handshake.
//   - FRAME_LEN=65535 is legal; no overflow is possible since the counts are bounded by the 16-bit registers.
//  BUSY = (state==RUN).
//  Reset mid-run returns everything to reset values immediately; no TLAST is emitted.
// TESTING
//  1. Write/read 0x4=0x0010 and 0x8=0x0003 -> reads return 0x00000010 and 0x00000003; every BRESP and RRESP is OKAY.
//  2. FRAME_LEN=4, NUM_FRAMES=2, CTRL=0x3, stream 0x01..0x08 with m_tready=1 -> TLAST on 0x04 and 0x08; then STATUS=0x00020002.
//  3. Same run with m_tready toggling 1/0 every cycle -> identical output beats and TLAST positions; no beat lost or duplicated.
//  4. CTRL=0x2 (START with EN=0) -> stays IDLE, STATUS[2]=1; writing STATUS=0x4 clears it to 0.
//  5. FRAME_LEN=8, NUM_FRAMES=1, abort after 3 beats (CTRL=0x5) -> BUSY=0, ERR=1, FRAMES_DONE=0, no TLAST seen.
//  6. Write FRAME_LEN=2 during a run with FRAME_LEN=4 -> the current run keeps TLAST every 4 beats; the next START uses 2.

Source files
------------

// File: rtl/demod_frame_sequencer.sv
// Frame sequencer: an AXI4-Lite programmed gate that turns the demodulator's
// symbol stream into FRAME_LEN x NUM_FRAMES beats of AXI-Stream with TLAST per frame.
module demod_frame_sequencer #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4,
  parameter int C_AXIS_TDATA_WIDTH = 32
) (
  input  logic                            i_aclk,
  input  logic                            i_aresetn,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   i_s_axi_awaddr,
  input  logic                            i_s_axi_awvalid,
  output logic                            o_s_axi_awready,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   i_s_axi_wdata,
  input  logic                            i_s_axi_wvalid,
  output logic                            o_s_axi_wready,
  output logic [1:0]                      o_s_axi_bresp,
  output logic                            o_s_axi_bvalid,
  input  logic                            i_s_axi_bready,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   i_s_axi_araddr,
  input  logic                            i_s_axi_arvalid,
  output logic                            o_s_axi_arready,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   o_s_axi_rdata,
  output logic [1:0]                      o_s_axi_rresp,
  output logic                            o_s_axi_rvalid,
  input  logic                            i_s_axi_rready,
  input  logic [C_AXIS_TDATA_WIDTH-1:0]   i_s_axis_tdata,
  input  logic                            i_s_axis_tvalid,
  output logic                            o_s_axis_tready,
  output logic [C_AXIS_TDATA_WIDTH-1:0]   o_m_axis_tdata,
  output logic                            o_m_axis_tvalid,
  input  logic                            i_m_axis_tready,
  output logic                            o_m_axis_tlast
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  logic [0:0]                    r_state;
  logic                          r_awready;
  logic                          r_bvalid;
  logic                          r_arready;
  logic                          r_rvalid;
  logic [C_S_AXI_DATA_WIDTH-1:0] r_rdata;
  logic                          r_en;
  logic [15:0]                   r_frame_len;
  logic [15:0]                   r_num_frames;
  logic [15:0]                   r_len_sh;
  logic [15:0]                   r_num_sh;
  logic [15:0]                   r_beat_cnt;
  logic [15:0]                   r_frames_done;
  logic                          r_done;
  logic                          r_err;

  logic                          w_run;
  logic                          w_wr;
  logic                          w_rd;
  logic [1:0]                    w_wsel;
  logic                          w_ctrl_wr;
  logic                          w_start;
  logic                          w_start_ok;
  logic                          w_stop;
  logic                          w_hs;
  logic                          w_last_beat;
  logic                          w_last_frame;
  logic [C_S_AXI_DATA_WIDTH-1:0] w_rdata;
  logic                          w_unused_ok;

  assign w_run        = (r_state == S_RUN);
  assign w_wr         = r_awready & i_s_axi_awvalid & i_s_axi_wvalid;
  assign w_rd         = r_arready & i_s_axi_arvalid;
  assign w_wsel       = i_s_axi_awaddr[3:2];
  assign w_ctrl_wr    = w_wr & (w_wsel == 2'd0);
  assign w_start      = w_ctrl_wr & i_s_axi_wdata[1];
  // EN is taken from the same write so CTRL=0x3 both enables and starts.
  assign w_start_ok   = w_start & i_s_axi_wdata[0] & (r_frame_len != 16'd0) & (r_num_frames != 16'd0);
  assign w_stop       = w_ctrl_wr & (i_s_axi_wdata[2] | ~i_s_axi_wdata[0]);
  assign w_hs         = w_run & i_s_axis_tvalid & i_m_axis_tready;
  assign w_last_beat  = (r_beat_cnt == (r_len_sh - 16'd1));
  assign w_last_frame = ((r_frames_done + 16'd1) == r_num_sh);
  assign w_unused_ok  = ^{i_s_axi_wdata[31:16], i_s_axi_awaddr[1:0], i_s_axi_araddr[1:0]};

  always_comb begin
    w_rdata = '0;
    case (i_s_axi_araddr[3:2])
      2'd0:    w_rdata = {31'd0, r_en};
      2'd1:    w_rdata = {16'd0, r_frame_len};
      2'd2:    w_rdata = {16'd0, r_num_frames};
      default: w_rdata = {r_frames_done, 13'd0, r_err, r_done, w_run};
    endcase
  end

  assign o_s_axi_awready = r_awready;
  assign o_s_axi_wready  = r_awready;
  assign o_s_axi_bvalid  = r_bvalid;
  assign o_s_axi_bresp   = 2'b00;
  assign o_s_axi_arready = r_arready;
  assign o_s_axi_rvalid  = r_rvalid;
  assign o_s_axi_rdata   = r_rdata;
  assign o_s_axi_rresp   = 2'b00;

  // Idle with EN=1 drains the demodulator; idle with EN=0 stalls it.
  assign o_m_axis_tdata  = i_s_axis_tdata;
  assign o_m_axis_tvalid = w_run & i_s_axis_tvalid;
  assign o_m_axis_tlast  = w_run & w_last_beat;
  assign o_s_axis_tready = w_run ? i_m_axis_tready : r_en;

  always_ff @(posedge i_aclk or negedge i_aresetn) begin
    if (!i_aresetn) begin
      r_awready <= 1'b0;
      r_bvalid  <= 1'b0;
      r_arready <= 1'b0;
      r_rvalid  <= 1'b0;
      r_rdata   <= '0;
    end else begin
      r_awready <= i_s_axi_awvalid & i_s_axi_wvalid & ~r_bvalid & ~r_awready;
      if (w_wr)
        r_bvalid <= 1'b1;
      else if (i_s_axi_bready)
        r_bvalid <= 1'b0;
      r_arready <= i_s_axi_arvalid & ~r_rvalid & ~r_arready;
      if (w_rd) begin
        r_rvalid <= 1'b1;
        r_rdata  <= w_rdata;
      end else if (i_s_axi_rready) begin
        r_rvalid <= 1'b0;
      end
    end
  end

  always_ff @(posedge i_aclk or negedge i_aresetn) begin
    if (!i_aresetn) begin
      r_state       <= S_IDLE;
      r_en          <= 1'b0;
      r_frame_len   <= '0;
      r_num_frames  <= '0;
      r_len_sh      <= '0;
      r_num_sh      <= '0;
      r_beat_cnt    <= '0;
      r_frames_done <= '0;
      r_done        <= 1'b0;
      r_err         <= 1'b0;
    end else begin
      if (w_wr) begin
        case (w_wsel)
          2'd0:    r_en         <= i_s_axi_wdata[0];
          2'd1:    r_frame_len  <= i_s_axi_wdata[15:0];
          2'd2:    r_num_frames <= i_s_axi_wdata[15:0];
          default: if (i_s_axi_wdata[2]) r_err <= 1'b0;
        endcase
      end
      case (r_state)
        S_IDLE: begin
          if (w_start_ok) begin
            r_state       <= S_RUN;
            r_done        <= 1'b0;
            r_frames_done <= '0;
            r_beat_cnt    <= '0;
            r_len_sh      <= r_frame_len;
            r_num_sh      <= r_num_frames;
          end else if (w_start) begin
            r_err <= 1'b1;
          end
        end
        default: begin
          if (w_hs) begin
            if (w_last_beat) begin
              r_beat_cnt    <= '0;
              r_frames_done <= r_frames_done + 16'd1;
            end else begin
              r_beat_cnt <= r_beat_cnt + 16'd1;
            end
          end
          // A stop request wins over completion landing on the same edge.
          if (w_stop) begin
            r_state <= S_IDLE;
            r_err   <= 1'b1;
          end else if (w_hs && w_last_beat && w_last_frame) begin
            r_state <= S_IDLE;
            r_done  <= 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_demod_frame_sequencer.sv
// Scoreboard bench for demod_frame_sequencer: expected beats and register reads
// are queued at issue time and checked by a free-running monitor.
module tb_demod_frame_sequencer;

  typedef struct {
    logic [31:0] data;
    logic        last;
  } beat_t;

  typedef struct {
    string       name;
    logic [31:0] val;
    logic [31:0] mask;
  } rd_t;

  logic        clk;
  logic        rstN;
  logic [3:0]  awaddr;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [3:0]  araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;
  logic [31:0] sTdata;
  logic        sTvalid;
  logic        sTready;
  logic [31:0] mTdata;
  logic        mTvalid;
  logic        mTready;
  logic        mTlast;

  int    testsRun;
  int    testsFailed;
  int    readyMode;
  int    runBeat;
  logic [31:0] seqData;
  beat_t expQ[$];
  rd_t   rdQ[$];

  demod_frame_sequencer dut (
    .i_aclk          (clk),
    .i_aresetn       (rstN),
    .i_s_axi_awaddr  (awaddr),
    .i_s_axi_awvalid (awvalid),
    .o_s_axi_awready (awready),
    .i_s_axi_wdata   (wdata),
    .i_s_axi_wvalid  (wvalid),
    .o_s_axi_wready  (wready),
    .o_s_axi_bresp   (bresp),
    .o_s_axi_bvalid  (bvalid),
    .i_s_axi_bready  (bready),
    .i_s_axi_araddr  (araddr),
    .i_s_axi_arvalid (arvalid),
    .o_s_axi_arready (arready),
    .o_s_axi_rdata   (rdata),
    .o_s_axi_rresp   (rresp),
    .o_s_axi_rvalid  (rvalid),
    .i_s_axi_rready  (rready),
    .i_s_axis_tdata  (sTdata),
    .i_s_axis_tvalid (sTvalid),
    .o_s_axis_tready (sTready),
    .o_m_axis_tdata  (mTdata),
    .o_m_axis_tvalid (mTvalid),
    .i_m_axis_tready (mTready),
    .o_m_axis_tlast  (mTlast)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Downstream ready pattern: 0 = always ready, 1 = toggle each cycle, 2 = random.
  initial begin
    mTready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (readyMode)
        0:       mTready = 1'b1;
        1:       mTready = ~mTready;
        default: mTready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (rstN && mTvalid && mTready) begin
        if (expQ.size() == 0) begin
          checkOutput("unexpected_beat", mTdata, 32'hDEAD_BEEF);
        end else begin
          beat_t e;
          e = expQ.pop_front();
          checkOutput("beat_data", mTdata, e.data);
          checkOutput("beat_last", {31'd0, mTlast}, {31'd0, e.last});
        end
      end
      if (rstN && rvalid && rready) begin
        if (rdQ.size() == 0) begin
          checkOutput("unexpected_read", rdata, 32'hDEAD_BEEF);
        end else begin
          rd_t r;
          r = rdQ.pop_front();
          checkOutput(r.name, rdata & r.mask, r.val & r.mask);
          checkOutput({r.name, "_rresp"}, {30'd0, rresp}, 32'd0);
        end
      end
    end
  end

  task automatic axiWrite(input logic [3:0] addr, input logic [31:0] data);
    bit ok;
    awaddr  = addr;
    wdata   = data;
    awvalid = 1'b1;
    wvalid  = 1'b1;
    ok = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (awready && wready) begin
        ok = 1;
        break;
      end
    end
    @(posedge clk);
    #1;
    awvalid = 1'b0;
    wvalid  = 1'b0;
    if (!ok) checkOutput("aw_timeout", 32'd0, 32'd1);
    bready = 1'b1;
    ok = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bvalid) begin
        ok = 1;
        break;
      end
    end
    if (ok) checkOutput("bresp", {30'd0, bresp}, 32'd0);
    else    checkOutput("b_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    bready = 1'b0;
  endtask

  task automatic axiRead(input string name, input logic [3:0] addr,
                         input logic [31:0] exp, input logic [31:0] mask);
    bit ok;
    rd_t r;
    araddr  = addr;
    arvalid = 1'b1;
    ok = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (arready) begin
        ok = 1;
        break;
      end
    end
    @(posedge clk);
    #1;
    arvalid = 1'b0;
    if (!ok) checkOutput({name, "_ar_timeout"}, 32'd0, 32'd1);
    r.name = name;
    r.val  = exp;
    r.mask = mask;
    rdQ.push_back(r);
    rready = 1'b1;
    ok = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (rvalid) begin
        ok = 1;
        break;
      end
    end
    if (!ok) begin
      void'(rdQ.pop_back());
      checkOutput({name, "_r_timeout"}, 32'd0, 32'd1);
    end
    @(posedge clk);
    #1;
    rready = 1'b0;
  endtask

  // Feeds nBeats symbols; the model marks TLAST purely from the beat index within the run.
  task automatic applyStimulus(input int nBeats, input int frameLen, input bit useRandom);
    beat_t e;
    bit ok;
    for (int k = 0; k < nBeats; k++) begin
      if (useRandom) e.data = $urandom;
      else begin
        seqData = seqData + 32'd1;
        e.data  = seqData;
      end
      e.last = ((runBeat % frameLen) == frameLen - 1);
      runBeat++;
      expQ.push_back(e);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
      sTdata  = e.data;
      sTvalid = 1'b1;
      ok = 0;
      for (int i = 0; i < 200; i++) begin
        @(negedge clk);
        if (sTready) begin
          ok = 1;
          break;
        end
      end
      @(posedge clk);
      #1;
      sTvalid = 1'b0;
      if (!ok) begin
        void'(expQ.pop_back());
        checkOutput("stream_timeout", 32'd0, 32'd1);
      end
    end
  endtask

  task automatic drainCheck(input string name);
    for (int i = 0; i < 100; i++) begin
      if (expQ.size() == 0) break;
      @(posedge clk);
    end
    checkOutput(name, expQ.size(), 32'd0);
  endtask

  task automatic startRun(input int len, input int num);
    axiWrite(4'h4, len);
    axiWrite(4'h8, num);
    runBeat = 0;
    axiWrite(4'h0, 32'h3);
  endtask

  initial begin
    int len;
    int num;
    int half;
    testsRun    = 0;
    testsFailed = 0;
    readyMode   = 0;
    runBeat     = 0;
    seqData     = 0;
    rstN    = 1'b0;
    awaddr  = '0;
    awvalid = 1'b0;
    wdata   = '0;
    wvalid  = 1'b0;
    bready  = 1'b0;
    araddr  = '0;
    arvalid = 1'b0;
    rready  = 1'b0;
    sTdata  = '0;
    sTvalid = 1'b0;

    #13;
    checkOutput("rst_awready", {31'd0, awready}, 32'd0);
    checkOutput("rst_bvalid",  {31'd0, bvalid},  32'd0);
    checkOutput("rst_arready", {31'd0, arready}, 32'd0);
    checkOutput("rst_rvalid",  {31'd0, rvalid},  32'd0);
    checkOutput("rst_mtvalid", {31'd0, mTvalid}, 32'd0);
    checkOutput("rst_stready", {31'd0, sTready}, 32'd0);
    checkOutput("rst_mtlast",  {31'd0, mTlast},  32'd0);
    repeat (2) @(posedge clk);
    #1;
    rstN = 1'b1;
    @(posedge clk);
    #1;
    axiRead("rst_status", 4'hC, 32'h0, 32'hFFFF_FFFF);
    axiRead("rst_ctrl",   4'h0, 32'h0, 32'hFFFF_FFFF);

    axiWrite(4'h4, 32'h10);
    axiWrite(4'h8, 32'h3);
    axiRead("rw_frame_len",  4'h4, 32'h10, 32'hFFFF_FFFF);
    axiRead("rw_num_frames", 4'h8, 32'h3,  32'hFFFF_FFFF);

    $display("[TB] basic run, downstream always ready");
    readyMode = 0;
    seqData   = 0;
    startRun(4, 2);
    applyStimulus(8, 4, 1'b0);
    drainCheck("run1_drain");
    axiRead("run1_status", 4'hC, 32'h0002_0002, 32'hFFFF_FFFF);

    $display("[TB] basic run, downstream toggling");
    readyMode = 1;
    seqData   = 0;
    startRun(4, 2);
    applyStimulus(8, 4, 1'b0);
    drainCheck("run2_drain");
    axiRead("run2_status", 4'hC, 32'h0002_0002, 32'hFFFF_FFFF);
    readyMode = 0;

    $display("[TB] START with EN=0");
    axiWrite(4'h0, 32'h2);
    axiRead("noen_status", 4'hC, 32'h4, 32'h5);
    #1;
    sTvalid = 1'b1;
    @(negedge clk);
    checkOutput("noen_stready", {31'd0, sTready}, 32'd0);
    checkOutput("idle_mtvalid", {31'd0, mTvalid}, 32'd0);
    @(posedge clk);
    #1;
    sTvalid = 1'b0;
    axiWrite(4'hC, 32'h4);
    axiRead("w1c_status", 4'hC, 32'h0, 32'h5);
    axiWrite(4'h0, 32'h1);
    sTvalid = 1'b1;
    @(negedge clk);
    checkOutput("flush_stready", {31'd0, sTready}, 32'd1);
    checkOutput("flush_mtvalid", {31'd0, mTvalid}, 32'd0);
    @(posedge clk);
    #1;
    sTvalid = 1'b0;
    axiWrite(4'h4, 32'h0);
    axiWrite(4'h0, 32'h3);
    axiRead("zero_len_status", 4'hC, 32'h4, 32'h5);
    axiWrite(4'hC, 32'h4);

    $display("[TB] abort mid-frame");
    startRun(8, 1);
    applyStimulus(3, 8, 1'b1);
    axiWrite(4'h0, 32'h5);
    drainCheck("abort_drain");
    axiRead("abort_status", 4'hC, 32'h0000_0004, 32'hFFFF_FFFF);
    axiWrite(4'hC, 32'h4);

    $display("[TB] shadowed frame length");
    startRun(4, 2);
    applyStimulus(2, 4, 1'b1);
    axiWrite(4'h4, 32'h2);
    applyStimulus(6, 4, 1'b1);
    drainCheck("shadow_drain");
    axiRead("shadow_status", 4'hC, 32'h0002_0002, 32'hFFFF_FFFF);
    axiRead("shadow_len",    4'h4, 32'h2,         32'hFFFF_FFFF);
    runBeat = 0;
    axiWrite(4'h0, 32'h3);
    applyStimulus(4, 2, 1'b1);
    drainCheck("shadow2_drain");
    axiRead("shadow2_status", 4'hC, 32'h0002_0002, 32'hFFFF_FFFF);

    $display("[TB] randomized runs with a START issued mid-run");
    readyMode = 2;
    for (int it = 0; it < 5; it++) begin
      len  = (it == 0) ? 1 : int'($urandom_range(1, 6));
      num  = int'($urandom_range(1, 3));
      half = (len * num) / 2;
      startRun(len, num);
      applyStimulus(half, len, 1'b1);
      axiWrite(4'h0, 32'h3);
      applyStimulus(len * num - half, len, 1'b1);
      drainCheck("rand_drain");
      axiRead("rand_status", 4'hC, (32'(num) << 16) | 32'h2, 32'hFFFF_FFFF);
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL global_timeout: simulation did not finish, got 0 expected 1");
    $fatal(1, "[TB] timeout");
  end

endmodule
